// File: rtl/img_pkg.sv
// Shared sizes, bank codes and writer state encoding for the image memory writer.
package img_pkg;

  localparam int LINE_W    = 256;
  localparam int NUM_LINES = 256;
  localparam int ADDR_W    = 8;

  localparam logic [2:0] BANK_OLD = 3'd0;
  localparam logic [2:0] BANK_NEW = 3'd1;
  localparam logic [2:0] BANK_BG  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } writer_state_t;

endpackage

// File: rtl/line_packer.sv
// Column counter plus line insert register: pixel k of a line lands in bit LINE_W-1-k.
module line_packer
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic              pix_in,
  output logic              line_full,
  output logic [LINE_W-1:0] packed_word
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);

  logic [ADDR_W-1:0] col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign line_full = (col_q == LAST_COL);

  // The register is always zero at and beyond col, so OR-ing in the new pixel is enough.
  always_comb begin
    packed_word = line_q | ({{(LINE_W - 1){1'b0}}, pix_in} << (LAST_COL - col_q));
    col_d       = col_q;
    line_d      = line_q;
    if (clear || (accept && line_full)) begin
      col_d  = '0;
      line_d = '0;
    end else if (accept) begin
      col_d  = col_q + 1'b1;
      line_d = packed_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/image_line_writer.sv
// Packs a serial 1-bit pixel stream into 256-bit line words and writes one word per row
// into the OLD or NEW image memory selected at start.
module image_line_writer
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        bank_sel,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              start_err,
  output logic              wr_en,
  output logic [2:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_LINES - 1);

  writer_state_t     state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]        wr_bank_q, wr_bank_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic              start_err_q, start_err_d;
  logic              accept, start_ok, line_full;
  logic [LINE_W-1:0] packed_word;

  assign accept   = pix_valid && (state_q == FILL);
  assign start_ok = start && (state_q == IDLE) && (bank_sel <= BANK_NEW);

  line_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .accept      (accept),
    .pix_in      (pix_data),
    .line_full   (line_full),
    .packed_word (packed_word)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d   = FILL;
          wr_bank_d = bank_sel;
          row_d     = '0;
        end else if (start) begin
          start_err_d = 1'b1;
        end
      end
      FILL: begin
        // Write registers are separate from the packer, so the next line keeps streaming.
        if (accept && line_full) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_q;
          wr_data_d = packed_word;
          row_d     = row_q + 1'b1;
          if (row_q == LAST_ROW) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      wr_addr_q    <= '0;
      wr_bank_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      wr_addr_q    <= wr_addr_d;
      wr_bank_q    <= wr_bank_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign pix_ready  = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;
  assign wr_en      = wr_en_q;
  assign wr_bank    = wr_bank_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_image_line_writer.sv
// Self-checking bench for image_line_writer against an image-array reference model.
module tb_image_line_writer;
  import img_pkg::*;

  localparam int FRAME_PIX = LINE_W * NUM_LINES;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        bank_sel;
  logic              pix_valid;
  logic              pix_data;
  logic              pix_ready;
  logic              busy;
  logic              frame_done;
  logic              start_err;
  logic              wr_en;
  logic [2:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;

  int checks = 0;
  int errors = 0;
  bit img [NUM_LINES][LINE_W];

  image_line_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bank_sel   (bank_sel),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .start_err  (start_err),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  // Expected memory word for row r: pixel c of the row sits at bit LINE_W-1-c.
  function automatic logic [LINE_W-1:0] exp_word(int r);
    logic [LINE_W-1:0] w;
    for (int c = 0; c < LINE_W; c++) w[LINE_W-1-c] = img[r][c];
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bank_sel = 3'd0; pix_valid = 1'b0; pix_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pix_ready, busy, frame_done, start_err, wr_en} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000", {pix_ready, busy, frame_done, start_err, wr_en});
    end
    checks++;
    if ({wr_bank, wr_addr} !== 11'd0 || wr_data !== '0) begin
      errors++; $display("FAIL reset_wr got bank=%0d addr=%0d data=%h want 0", wr_bank, wr_addr, wr_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_bad_bank();
    logic [2:0] codes [2];
    codes[0] = 3'd3;
    codes[1] = 3'($urandom_range(2, 7));
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; bank_sel = codes[k]; pix_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (start_err !== 1'b1) begin
        errors++; $display("FAIL bad_bank_err code=%0d got=%b want=1", codes[k], start_err);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({busy, pix_ready, wr_en} !== 3'b000) begin
          errors++; $display("FAIL bad_bank_idle code=%0d cyc=%0d got busy/ready/wr=%b want=000", codes[k], i, {busy, pix_ready, wr_en});
        end
        @(posedge clk); #1;
        checks++;
        if (start_err !== 1'b0) begin
          errors++; $display("FAIL bad_bank_pulse code=%0d got=%b want=0", codes[k], start_err);
        end
      end
      pix_valid = 1'b0;
      $display("start rejected for bank code %0d", codes[k]);
    end
  endtask

  // Full frame into NEW: diagonal image with an all-ones first line, random rows 2..3,
  // toggling valid for the first two lines and a stray start mid-frame.
  task automatic test_frame();
    int acc, cyc, writes, obs_writes;
    bit exp_acc, exp_wr, exp_done;
    logic [LINE_W-1:0] last_word;
    for (int r = 0; r < NUM_LINES; r++)
      for (int c = 0; c < LINE_W; c++)
        img[r][c] = (r == 0) ? 1'b1 : ((r == 2 || r == 3) ? 1'($urandom) : (c == r));
    start = 1'b1; bank_sel = BANK_NEW;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, pix_ready, start_err} !== 3'b110) begin
      errors++; $display("FAIL frame_start got busy/ready/err=%b want=110", {busy, pix_ready, start_err});
    end
    acc = 0; cyc = 0; writes = 0; obs_writes = 0; last_word = '0;
    while (acc < FRAME_PIX && cyc < 70000) begin
      if (acc < 2 * LINE_W) pix_valid = (cyc % 2 == 0);
      else if ((acc % LINE_W) >= LINE_W - 6 || (acc % LINE_W) < 6) pix_valid = 1'b1;
      else pix_valid = ($urandom_range(0, 63) != 0);
      pix_data = pix_valid ? img[acc / LINE_W][acc % LINE_W] : 1'($urandom);
      if (acc == 300 && pix_valid) begin
        start = 1'b1; bank_sel = BANK_OLD;
      end
      exp_acc  = pix_valid;
      exp_wr   = exp_acc && (acc % LINE_W == LINE_W - 1);
      exp_done = exp_acc && (acc == FRAME_PIX - 1);
      @(posedge clk); #1;
      start = 1'b0;
      if (exp_acc) acc++;
      cyc++;
      if (wr_en === 1'b1) obs_writes++;
      checks++;
      if (wr_en !== exp_wr) begin
        errors++; $display("FAIL frame_wr_en pix=%0d got=%b want=%b", acc, wr_en, exp_wr);
      end
      checks++;
      if (frame_done !== exp_done) begin
        errors++; $display("FAIL frame_done pix=%0d got=%b want=%b", acc, frame_done, exp_done);
      end
      checks++;
      if (pix_ready !== (acc < FRAME_PIX) || busy !== 1'b1 || start_err !== 1'b0) begin
        errors++; $display("FAIL frame_status pix=%0d got ready/busy/err=%b%b%b want=%b10", acc, pix_ready, busy, start_err, acc < FRAME_PIX);
      end
      if (exp_wr) begin
        last_word = exp_word(writes);
        checks++;
        if (wr_addr !== ADDR_W'(writes) || wr_bank !== BANK_NEW || wr_data !== last_word) begin
          errors++; $display("FAIL frame_write got addr=%0d bank=%0d data=%h want addr=%0d bank=1 data=%h", wr_addr, wr_bank, wr_data, writes, last_word);
        end
        $display("write addr=%0d bank=%0d", wr_addr, wr_bank);
        writes++;
      end else if (writes > 0) begin
        checks++;
        if (wr_data !== last_word || wr_bank !== BANK_NEW) begin
          errors++; $display("FAIL frame_hold got bank=%0d data=%h want bank=1 data=%h", wr_bank, wr_data, last_word);
        end
      end
    end
    pix_valid = 1'b0;
    if (acc < FRAME_PIX) begin
      errors++; $display("FAIL frame_timeout got=%0d pixels want=%0d", acc, FRAME_PIX);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, pix_ready, wr_en, frame_done} !== 4'b0000) begin
      errors++; $display("FAIL frame_end got busy/ready/wr/done=%b want=0000", {busy, pix_ready, wr_en, frame_done});
    end
    checks++;
    if (obs_writes !== NUM_LINES) begin
      errors++; $display("FAIL frame_write_count got=%0d want=%0d", obs_writes, NUM_LINES);
    end
    $display("frame complete: %0d pixels in %0d cycles", acc, cyc);
  endtask

  // Reset asserted 100 pixels into line 5 of an OLD frame.
  task automatic test_reset_midframe();
    int acc, writes;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < LINE_W; c++) img[r][c] = 1'($urandom);
    start = 1'b1; bank_sel = BANK_OLD;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; writes = 0;
    while (acc < 5 * LINE_W + 100) begin
      pix_valid = 1'b1;
      pix_data  = img[acc / LINE_W][acc % LINE_W];
      @(posedge clk); #1;
      acc++;
      if (acc % LINE_W == 0) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(writes) || wr_bank !== BANK_OLD || wr_data !== exp_word(writes)) begin
          errors++; $display("FAIL old_write got en=%b addr=%0d bank=%0d data=%h want en=1 addr=%0d bank=0 data=%h", wr_en, wr_addr, wr_bank, wr_data, writes, exp_word(writes));
        end
        $display("write addr=%0d bank=%0d", wr_addr, wr_bank);
        writes++;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, pix_ready, wr_en, frame_done, start_err, wr_bank, wr_addr} !== 16'd0 || wr_data !== '0) begin
      errors++; $display("FAIL async_reset got busy/ready/wr=%b%b%b bank=%0d addr=%0d data=%h want all 0", busy, pix_ready, wr_en, wr_bank, wr_addr, wr_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst = 1'b0;
      checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_no_write cyc=%0d got wr/busy=%b%b want=00", i, wr_en, busy);
      end
    end
    pix_valid = 1'b0;
    $display("reset mid-frame after %0d pixels", acc);
  endtask

  // New frame after the abort must begin at row 0 with freshly packed data.
  task automatic test_restart();
    int acc, cyc;
    bit seen;
    logic [2:0] bank;
    bank = 3'($urandom_range(0, 1));
    for (int c = 0; c < LINE_W; c++) img[0][c] = 1'($urandom);
    start = 1'b1; bank_sel = bank;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      pix_valid = (acc < LINE_W) && ($urandom_range(0, 3) != 0);
      pix_data  = pix_valid ? img[0][acc] : 1'($urandom);
      @(posedge clk); #1;
      if (pix_valid) acc++;
      cyc++;
      if (wr_en === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (acc !== LINE_W || wr_addr !== '0 || wr_bank !== bank || wr_data !== exp_word(0)) begin
          errors++; $display("FAIL restart_write got pix=%0d addr=%0d bank=%0d data=%h want pix=%0d addr=0 bank=%0d data=%h", acc, wr_addr, wr_bank, wr_data, LINE_W, bank, exp_word(0));
        end
        $display("write addr=%0d bank=%0d", wr_addr, wr_bank);
      end
    end
    pix_valid = 1'b0;
    if (!seen) begin
      errors++; $display("FAIL restart_timeout got no write want addr=0 write");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bad_bank();
    test_frame();
    test_reset_midframe();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
